// File: rtl/digit_serial_add_sub.sv
// Digit-serial adder/subtractor: LSB-first words of DIGIT_W-bit digits, first/last framing, per-word add/sub.
// Define DIGIT_SERIAL_ADD_SUB_OVERFLOW_EN to compute the signed overflow flag; otherwise it is tied 0.
module digit_serial_add_sub #(
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               in_last,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               out_valid,
  output logic               out_first,
  output logic               out_last,
  output logic [DIGIT_W-1:0] sum,
  output logic               carry_out,
  output logic               overflow,
  output logic               proto_err
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic {IDLE, IN_WORD} state_t;

  state_t          state;
  logic            carry_reg;
  logic            sub_reg;
  logic [CW-1:0]   count;

  logic               in_word;
  logic               accept;
  logic               mode;
  logic               c_in;
  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W:0]   full;
  logic               c_next;
  logic [DIGIT_W-1:0] s;
  logic [CW-1:0]      cnt_next;
  logic               max_hit;
  logic               word_end;
  logic               err;
  logic               ovf_calc;

  assign in_word  = (state == IN_WORD);
  // A first digit is always accepted; it restarts any open word.
  assign accept   = in_valid & (in_first | in_word);
  assign mode     = in_first ? sub : sub_reg;
  assign c_in     = in_first ? sub : carry_reg;
  assign b_eff    = mode ? ~b : b;
  assign full     = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, c_in};
  assign c_next   = full[DIGIT_W];
  assign s        = full[DIGIT_W-1:0];
  assign cnt_next = in_first ? CW'(1) : count + CW'(1);
  assign max_hit  = (cnt_next == CW'(MAX_DIGITS)) & ~in_last;
  assign word_end = in_last | max_hit;
  // Orphan digit in IDLE, restart mid-word, or word truncated at MAX_DIGITS.
  assign err      = (in_valid & (in_first ? in_word : ~in_word)) | (accept & max_hit);

`ifdef DIGIT_SERIAL_ADD_SUB_OVERFLOW_EN
  logic c_msb;
  assign c_msb    = a[DIGIT_W-1] ^ b_eff[DIGIT_W-1] ^ s[DIGIT_W-1];
  assign ovf_calc = c_msb ^ c_next;
`else
  assign ovf_calc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      carry_reg <= 1'b0;
      sub_reg   <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      out_valid <= accept;
      out_first <= accept & in_first;
      out_last  <= accept & word_end;
      sum       <= accept ? s : '0;
      carry_out <= accept & word_end & c_next;
      overflow  <= accept & word_end & ovf_calc;
      proto_err <= err;
      if (accept) begin
        carry_reg <= c_next;
        sub_reg   <= mode;
        count     <= cnt_next;
        state     <= word_end ? IDLE : IN_WORD;
      end
    end
  end
endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Scoreboard bench: word-level arithmetic model predicts each result digit; a monitor pops and compares.
module tb_digit_serial_add_sub;
  localparam int W   = 4;
  localparam int MAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic out_valid, out_first, out_last, carry_out, overflow, proto_err;
  logic [W-1:0] sum;

  digit_serial_add_sub #(.DIGIT_W(W), .MAX_DIGITS(MAX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .sub(sub), .a(a), .b(b), .out_valid(out_valid), .out_first(out_first),
    .out_last(out_last), .sum(sum), .carry_out(carry_out), .overflow(overflow),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [9:0] q[$];

  // Model state: the open word's operand prefixes as plain integers.
  bit     open = 1'b0;
  bit     m_sub;
  int     n_dig;
  longint acc_a, acc_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Result of the n-digit prefix: A+B or A-B with n*W-bit wraparound.
  function automatic void calc(input longint aa, input longint bb, input int n, input bit s,
                               output logic [W-1:0] d, output bit c, output bit v);
    longint m, r, sa, sb, t;
    m  = longint'(1) << (W * n);
    r  = s ? aa + m - bb : aa + bb;
    d  = W'((r >> (W * (n - 1))) & ((1 << W) - 1));
    c  = ((r >> (W * n)) & 1) != 0;
    sa = (aa >= m / 2) ? aa - m : aa;
    sb = (bb >= m / 2) ? bb - m : bb;
    t  = s ? sa - sb : sa + sb;
    v  = (t < -(m / 2)) || (t >= m / 2);
  endfunction

  task automatic drive(input bit v, input bit f, input bit l, input bit s,
                       input logic [W-1:0] da, input logic [W-1:0] db);
    logic [W-1:0] d;
    bit c, ov, restart, forced, is_last;
    @(posedge clk); #1;
    in_valid = v; in_first = f; in_last = l; sub = s; a = da; b = db;
    if (!v) return;
    restart = 1'b0;
    if (f) begin
      restart = open;
      open = 1'b1; m_sub = s; n_dig = 0; acc_a = 0; acc_b = 0;
    end else if (!open) begin
      q.push_back(10'b00_0_0000_001);
      return;
    end
    acc_a |= longint'(da) << (W * n_dig);
    acc_b |= longint'(db) << (W * n_dig);
    n_dig++;
    calc(acc_a, acc_b, n_dig, m_sub, d, c, ov);
    forced  = (n_dig == MAX) && !l;
    is_last = l || forced;
`ifndef DIGIT_SERIAL_ADD_SUB_OVERFLOW_EN
    ov = 1'b0;
`endif
    q.push_back({1'b1, f, is_last, d, c & is_last, ov & is_last, restart | forced});
    if (is_last) open = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
  endtask

  // Sends an n-digit word LSB-first, with `gap` idle cycles between digits.
  task automatic word(input longint wa, input longint wb, input int n, input bit s, input int gap);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, i == 0, i == n - 1, (i == 0) ? s : 1'($urandom),
            W'(wa >> (W * i)), W'(wb >> (W * i)));
      if (i != n - 1) idle(gap);
    end
  endtask

  task automatic do_reset(input bit with_digit);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = with_digit; in_first = 1'b1; in_last = 1'b0;
    a = W'($urandom); b = W'($urandom);
    open = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {22'b0, out_valid, out_first, out_last, sum, carry_out, overflow, proto_err}, 32'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1 || proto_err === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {22'b0, out_valid, out_first, out_last, sum, carry_out, overflow, proto_err}, 32'b0);
        end else begin
          logic [9:0] e;
          e = q.pop_front();
          chk("out", {22'b0, out_valid, out_first, out_last, sum, carry_out, overflow, proto_err}, {22'b0, e});
        end
      end else begin
        chk("idle_zero", {22'b0, out_valid, out_first, out_last, sum, carry_out, overflow, proto_err}, 32'b0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    word(64'h3C, 64'h5A, 2, 1'b0, 0);           // 0x96, carry 0, signed overflow
    word(64'h10, 64'h01, 2, 1'b1, 0);           // 0x0F, no borrow
    word(64'h01, 64'h10, 2, 1'b1, 0);           // 0xF1, borrow
    idle(1);
    word(64'h07, 64'h01, 2, 1'b0, 3);           // stalls between digits hold state
    idle(2);
    word(64'h9, 64'h8, 1, 1'b0, 0);             // single digit, then back-to-back word
    word(64'h7F, 64'h01, 2, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h4);  // orphan digit in IDLE
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 4'h6);  // word abandoned by restart
    word(64'h123, 64'h456, 3, 1'b1, 0);
    word(64'h1234, 64'h1111, 4, 1'b0, 0);       // exceeds MAX: truncated, then orphan
    idle(1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
    do_reset(1'b0);                              // mid-word reset discards the word
    word(64'h0F, 64'h01, 2, 1'b0, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
    do_reset(1'b1);                              // reset beats a simultaneous digit
    word(64'h00, 64'h00, 2, 1'b1, 0);

    for (int k = 0; k < 300; k++) begin
      int len, gap;
      len = $urandom_range(1, MAX + 1);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      if ($urandom_range(0, 15) == 0) drive(1'b1, 1'b0, 1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
      if ($urandom_range(0, 11) == 0 && len > 1) len = len - 1;
      for (int i = 0; i < len; i++) begin
        drive(1'b1, i == 0, (i == len - 1) && ($urandom_range(0, 9) != 0), 1'($urandom),
              W'($urandom), W'($urandom));
        if (gap > 0) idle(gap);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(4);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
